// File: rtl/bcd_divider_if.sv
// rtl/bcd_divider_if.sv - request/result bundle between a BCD divider client and the divider
interface bcd_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       error;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, error
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, error
    );
endinterface

// File: rtl/bcd_divider.sv
// rtl/bcd_divider.sv - sequential 2-digit / 1-digit packed-BCD divider by repeated subtraction
// Optional macro BCD_DIV_FAST_EN: subtract 10*divisor per edge for the tens digit first.
module bcd_divider (
    input  logic         clk,
    input  logic         rst_n,
    bcd_divider_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SUB,
        S_SUBT,
        S_SUBU,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [6:0] acc_q, acc_d;
    logic [7:0] qacc_q, qacc_d;
    logic [7:0] quot_q, quot_d;
    logic [3:0] rem_q, rem_d;
    logic       err_q, err_d;

    logic       bad_operands;
    logic [6:0] dvd_bin;
    logic [6:0] dvs_ext;
`ifdef BCD_DIV_FAST_EN
    logic [6:0] dvs_x10;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        bad_operands = (dvd_q[7:4] > 4'd9) || (dvd_q[3:0] > 4'd9) ||
                       (dvs_q > 4'd9) || (dvs_q == 4'd0);
        dvs_ext      = {3'b000, dvs_q};
        // tens*10 as shifts keeps the conversion a pair of adders
        dvd_bin      = ({3'b000, dvd_q[7:4]} << 3) + ({3'b000, dvd_q[7:4]} << 1) +
                       {3'b000, dvd_q[3:0]};
`ifdef BCD_DIV_FAST_EN
        dvs_x10      = (dvs_ext << 3) + (dvs_ext << 1);
`endif
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        acc_d   = acc_q;
        qacc_d  = qacc_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    qacc_d  = 8'h00;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_operands) begin
                    err_d   = 1'b1;
                    quot_d  = 8'h00;
                    rem_d   = 4'h0;
                    state_d = S_DONE;
                end else begin
                    acc_d   = dvd_bin;
`ifdef BCD_DIV_FAST_EN
                    state_d = S_SUBT;
`else
                    state_d = S_SUB;
`endif
                end
            end
`ifdef BCD_DIV_FAST_EN
            S_SUBT: begin
                if (acc_q >= dvs_x10) begin
                    acc_d       = acc_q - dvs_x10;
                    qacc_d[7:4] = qacc_q[7:4] + 4'd1;
                end else begin
                    state_d = S_SUBU;
                end
            end
`endif
            // in SUBU the units digit cannot pass 9, so the BCD carry never fires
            S_SUB, S_SUBU: begin
                if (acc_q >= dvs_ext) begin
                    acc_d  = acc_q - dvs_ext;
                    qacc_d = bcd_inc(qacc_q);
                end else begin
                    quot_d  = qacc_q;
                    rem_d   = acc_q[3:0];
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'h00;
            dvs_q   <= 4'h0;
            acc_q   <= 7'd0;
            qacc_q  <= 8'h00;
            quot_q  <= 8'h00;
            rem_q   <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            acc_q   <= acc_d;
            qacc_q  <= qacc_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.error     = err_q;
endmodule

// File: tb/tb_bcd_divider.sv
// tb/tb_bcd_divider.sv - scoreboard bench for bcd_divider: directed vectors, abort, full sweep
module tb_bcd_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_divider_if bus ();

    bcd_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       e;
        int         lat;
        int         t0;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       e;
        int         ls;
        int         lf;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   done_count = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    function automatic int lat_of(input int q);
`ifdef BCD_DIV_FAST_EN
        return q / 10 + q % 10 + 4;
`else
        return q + 3;
`endif
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            done_count++;
            check("done_width", int'(prev_done), 0);
            if (sbq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("quotient", int'(bus.quotient), int'(mon_e.q));
                check("remainder", int'(bus.remainder), int'(mon_e.r));
                check("error", int'(bus.error), int'(mon_e.e));
                check("latency", cyc - mon_e.t0 + 1, mon_e.lat);
            end
        end
        prev_done = bus.done;
    end

    task automatic issue(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                         input logic [3:0] r, input logic e, input int lat, output int edges);
        exp_t x;
        edges = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.busy && edges < 10);
        bus.start = 1'b0;
        if (!bus.busy) begin
            check("accept", 0, 1);
        end else begin
            x.q   = q;
            x.r   = r;
            x.e   = e;
            x.lat = lat;
            x.t0  = cyc;
            sbq.push_back(x);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        int drop;
        n = 0;
        drop = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
            if (!bus.busy) drop++;
        end
        if (!bus.done) begin
            check({name, "_timeout"}, 0, 1);
            sbq.delete();
        end else begin
            check({name, "_busy_high"}, drop, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   edges;
        int   dc;
        int   q;
        logic [7:0] a8;

        vecs[0] = '{8'h87, 4'd7, 8'h12, 4'd3, 1'b0, 15, 7};
        vecs[1] = '{8'h99, 4'd9, 8'h11, 4'd0, 1'b0, 14, 6};
        vecs[2] = '{8'h05, 4'd9, 8'h00, 4'd5, 1'b0, 3, 4};
        vecs[3] = '{8'h99, 4'd1, 8'h99, 4'd0, 1'b0, 102, 22};
        vecs[4] = '{8'hA0, 4'd2, 8'h00, 4'd0, 1'b1, 2, 2};
        vecs[5] = '{8'hA0, 4'd0, 8'h00, 4'd0, 1'b1, 2, 2};
        vecs[6] = '{8'hA0, 4'hC, 8'h00, 4'd0, 1'b1, 2, 2};
        vecs[7] = '{8'h50, 4'd0, 8'h00, 4'd0, 1'b1, 2, 2};
        vecs[8] = '{8'h5A, 4'd3, 8'h00, 4'd0, 1'b1, 2, 2};
        vecs[9] = '{8'h42, 4'd4, 8'h10, 4'd2, 1'b0, 13, 5};

        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.error}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
`ifdef BCD_DIV_FAST_EN
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].lf, edges);
`else
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].ls, edges);
`endif
            wait_done("directed");
            @(negedge clk);
        end

        // start pulsed mid-operation must be ignored
        dc = done_count;
        issue(8'h87, 4'd7, 8'h12, 4'd3, 1'b0, lat_of(12), edges);
        repeat (4) @(negedge clk);
        bus.dividend = 8'h55;
        bus.divisor  = 4'd5;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done("midstart");
        repeat (5) @(negedge clk);
        check("midstart_one_done", done_count - dc, 1);
        check("result_hold_q", int'(bus.quotient), 8'h12);
        check("result_hold_r", int'(bus.remainder), 3);

        // start held through the done cycle is taken on the second edge
        issue(8'h99, 4'd9, 8'h11, 4'd0, 1'b0, lat_of(11), edges);
        wait_done("b2b_first");
        issue(8'h05, 4'd9, 8'h00, 4'd5, 1'b0, lat_of(0), edges);
        check("b2b_accept_edges", edges, 2);
        wait_done("b2b_second");
        @(negedge clk);

        // asynchronous reset during SUB aborts with no done
        issue(8'h99, 4'd1, 8'h99, 4'd0, 1'b0, lat_of(99), edges);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", int'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.error}), 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        dc = done_count;
        repeat (120) @(negedge clk);
        check("abort_no_done", done_count - dc, 0);
        issue(8'h42, 4'd4, 8'h10, 4'd2, 1'b0, lat_of(10), edges);
        wait_done("after_abort");
        @(negedge clk);

        for (int n = 0; n < 100; n++) begin
            for (int d = 1; d < 10; d++) begin
                q  = n / d;
                a8 = 8'((n / 10) * 16 + n % 10);
                issue(a8, 4'(d), 8'((q / 10) * 16 + q % 10), 4'(n % d), 1'b0, lat_of(q), edges);
                wait_done("sweep");
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
